g_inverse_search: RTL



---
 rtl/hdr_pkg.sv | 15 +
 rtl/g_table_regfile.sv | 37 +++
 rtl/g_inverse_search.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hdr_pkg.sv
// Shared definitions for the HDR inverse-response engine: widths, table depth
// and the search FSM state encoding.
package hdr_pkg;

  localparam int PIX_W_DEF = 5;
  localparam int LOG_W_DEF = 8;
  localparam int TBL_DEPTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/g_table_regfile.sv
// Flop-based response table: one synchronous write port, reset to a linear ramp,
// and two combinational read ports (search candidate and fixed entry 0).
module g_table_regfile
  import hdr_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int LOG_W = LOG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [PIX_W-1:0] waddr_i,
  input  logic [LOG_W-1:0] wdata_i,
  input  logic [PIX_W-1:0] raddr_i,
  output logic [LOG_W-1:0] rdata_o,
  output logic [LOG_W-1:0] rdata0_o
);

  localparam int DEPTH = 2 ** PIX_W;

  logic [LOG_W-1:0] mem_q [DEPTH];

  // Default curve places index i in the top PIX_W bits of the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= LOG_W'(i) << (LOG_W - PIX_W);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o  = mem_q[raddr_i];
  assign rdata0_o = mem_q[0];

endmodule

// File: rtl/g_inverse_search.sv
// Inverse camera response: bit-serial binary search for the largest code whose
// table entry is <= the requested log-exposure value.
module g_inverse_search
  import hdr_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int LOG_W = LOG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOG_W-1:0] in_log,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_code,
  output logic             out_under,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] wr_addr,
  input  logic [LOG_W-1:0] wr_data,
  output logic             busy,
  output state_t           dbg_state
);

  // Handshakes: a transfer happens on an enabled edge where valid && ready;
  // out_valid and the result stay stable until that transfer completes.

  localparam int BW = (PIX_W > 1) ? $clog2(PIX_W) : 1;

  state_t           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [LOG_W-1:0] v_q, v_d;
  logic [PIX_W-1:0] res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_code_q, out_code_d;
  logic             out_under_q, out_under_d;

  logic [PIX_W-1:0] cand;
  logic [LOG_W-1:0] t_cand;
  logic [LOG_W-1:0] t_zero;
  logic             tbl_we;

  assign cand   = res_q | (PIX_W'(1) << bit_q);
  assign tbl_we = clk_en && wr_en && (state_q == ST_IDLE);

  g_table_regfile #(
    .PIX_W (PIX_W),
    .LOG_W (LOG_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .we_i     (tbl_we),
    .waddr_i  (wr_addr),
    .wdata_i  (wr_data),
    .raddr_i  (cand),
    .rdata_o  (t_cand),
    .rdata0_o (t_zero)
  );

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    v_d         = v_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_under_d = out_under_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SEARCH;
          v_d     = in_log;
          res_d   = '0;
          bit_d   = BW'(PIX_W - 1);
        end
      end
      ST_SEARCH: begin
        if (t_cand <= v_q) res_d = cand;
        if (bit_q == '0) state_d = ST_DONE;
        else             bit_d   = bit_q - BW'(1);
      end
      ST_DONE: begin
        // First DONE cycle registers the result; later cycles wait for the sink.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_code_d  = res_q;
          out_under_d = (v_q < t_zero);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      v_q         <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_under_q <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      v_q         <= v_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_under_q <= out_under_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_under = out_under_q;
  assign dbg_state = state_q;

endmodule
